// File: rtl/mouse_cmd_sequencer_if.sv
// Transceiver-side handshake between the command sequencer and the PS/2 mouse transceiver.
// The sequencer is the master: it requests transmissions and holds off the stream decoder.
interface mouse_cmd_sequencer_if;
  logic       send_byte;
  logic [7:0] tx_byte;
  logic       byte_sent;
  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       hold_stream;

  modport master (
    output send_byte,
    output tx_byte,
    output hold_stream,
    input  byte_sent,
    input  rx_ready,
    input  rx_byte
  );

  modport slave (
    input  send_byte,
    input  tx_byte,
    input  hold_stream,
    output byte_sent,
    output rx_ready,
    output rx_byte
  );
endinterface

// File: rtl/mouse_cmd_sequencer.sv
// Bus-mapped PS/2 host-to-mouse command sequencer: sends CMD (+ optional ARG),
// checks each response for ack/resend/error, retries on resend, times out on silence.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a CMD write
// SEND       | one-cycle transmit request for the current byte
// WAIT_SENT  | waiting for the transceiver to finish sending
// WAIT_RESP  | waiting for the mouse response byte
// DONE       | one cycle: latch DONE, optionally raise the interrupt
module mouse_cmd_sequencer #(
  parameter logic [7:0]  BASE_ADDR      = 8'hA4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            bus_addr_i,
  inout  wire  [7:0]            bus_data_io,
  input  logic                  bus_we_i,
  output logic                  bus_irq_raise_o,
  input  logic                  bus_irq_ack_i,
  mouse_cmd_sequencer_if.master xcvr
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [7:0]    RESP_ACK    = 8'hFA;
  localparam logic [7:0]    RESP_RESEND = 8'hFE;

  localparam logic [1:0] OFF_CMD  = 2'd0;
  localparam logic [1:0] OFF_ARG  = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_RESP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    arg_q, arg_d;
  logic [7:0]    resp_q, resp_d;
  logic          has_arg_q, has_arg_d;
  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic          nack_q, nack_d;
  logic [1:0]    retry_q, retry_d;
  logic          is_arg_q, is_arg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          raise_q, raise_d;
  logic [7:0]    rd_q, rd_d;
  logic          oe_q, oe_d;

  logic       win_hit;
  logic [1:0] off;
  logic       wr_hit;
  logic       rd_hit;
  logic       busy;
  logic [7:0] status;

  // The window is assumed 4-byte aligned, so the upper six address bits select it.
  assign win_hit = (bus_addr_i[7:2] == BASE_ADDR[7:2]);
  assign off     = bus_addr_i[1:0];
  assign wr_hit  = win_hit && bus_we_i;
  assign rd_hit  = win_hit && !bus_we_i;
  assign busy    = (state_q != ST_IDLE);
  assign status  = {busy, done_q, ovr_q, tmo_q, nack_q, 1'b0, retry_q};

  assign bus_data_io      = oe_q ? rd_q : 8'hzz;
  assign bus_irq_raise_o  = raise_q;
  assign xcvr.send_byte   = (state_q == ST_SEND);
  assign xcvr.tx_byte     = tx_q;
  assign xcvr.hold_stream = busy;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    arg_d     = arg_q;
    resp_d    = resp_q;
    has_arg_d = has_arg_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    nack_d    = nack_q;
    retry_d   = retry_q;
    is_arg_d  = is_arg_q;
    raise_d   = raise_q;
    timer_d   = timer_q;
    rd_d      = 8'h00;
    oe_d      = 1'b0;

    if (bus_irq_ack_i) begin
      raise_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_SEND: begin
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (xcvr.byte_sent) begin
          state_d = ST_WAIT_RESP;
        end else if (timer_q == '0) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_RESP: begin
        if (xcvr.rx_ready) begin
          resp_d = xcvr.rx_byte;
          if (xcvr.rx_byte == RESP_ACK) begin
            if (!is_arg_q && has_arg_q) begin
              tx_d     = arg_q;
              is_arg_d = 1'b1;
              retry_d  = 2'd0;
              state_d  = ST_SEND;
            end else begin
              state_d = ST_DONE;
            end
          end else if (xcvr.rx_byte == RESP_RESEND && retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_SEND;
          end else begin
            nack_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (timer_q == '0) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        // Setting has priority over a same-cycle acknowledge.
        if (irq_en_q) begin
          raise_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_hit) begin
      case (off)
        OFF_CMD: begin
          if (state_q == ST_IDLE) begin
            done_d   = 1'b0;
            tmo_d    = 1'b0;
            nack_d   = 1'b0;
            ovr_d    = 1'b0;
            retry_d  = 2'd0;
            is_arg_d = 1'b0;
            tx_d     = bus_data_io;
            state_d  = ST_SEND;
          end else begin
            ovr_d = 1'b1;
          end
        end
        OFF_ARG: begin
          arg_d = bus_data_io;
        end
        OFF_CTRL: begin
          has_arg_d = bus_data_io[0];
          irq_en_d  = bus_data_io[1];
        end
        default: begin
        end
      endcase
    end

    // Timeout down-counter reloads on every state change and stops at zero.
    if (state_d != state_q) begin
      timer_d = TMO_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    if (rd_hit) begin
      case (off)
        OFF_ARG: begin
          rd_d = arg_q;
          oe_d = 1'b1;
        end
        OFF_CTRL: begin
          rd_d = status;
          oe_d = 1'b1;
        end
        OFF_RESP: begin
          rd_d = resp_q;
          oe_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tx_q      <= 8'h00;
      arg_q     <= 8'h00;
      resp_q    <= 8'h00;
      has_arg_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      nack_q    <= 1'b0;
      retry_q   <= 2'd0;
      is_arg_q  <= 1'b0;
      timer_q   <= '0;
      raise_q   <= 1'b0;
      rd_q      <= 8'h00;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      arg_q     <= arg_d;
      resp_q    <= resp_d;
      has_arg_q <= has_arg_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
      nack_q    <= nack_d;
      retry_q   <= retry_d;
      is_arg_q  <= is_arg_d;
      timer_q   <= timer_d;
      raise_q   <= raise_d;
      rd_q      <= rd_d;
      oe_q      <= oe_d;
    end
  end

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
// Self-checking bench for mouse_cmd_sequencer: transmitted bytes are checked against
// a scoreboard queue, register reads and outputs against bench-computed constants.
module tb_mouse_cmd_sequencer;

  localparam logic [7:0] BASE = 8'hA4;
  localparam logic [7:0] A_CMD  = BASE + 8'd0;
  localparam logic [7:0] A_ARG  = BASE + 8'd1;
  localparam logic [7:0] A_CTRL = BASE + 8'd2;
  localparam logic [7:0] A_RESP = BASE + 8'd3;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [7:0] tb_data;
  logic       tb_drv;
  wire  [7:0] bus_data;
  logic       irq_raise;
  logic       irq_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int n_send  = 0;
  logic [7:0] exp_tx[$];
  logic hold_watch = 1'b0;
  logic hold_drop  = 1'b0;

  mouse_cmd_sequencer_if xif ();

  assign bus_data = tb_drv ? tb_data : 8'hzz;

  mouse_cmd_sequencer #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus_addr_i      (bus_addr),
    .bus_data_io     (bus_data),
    .bus_we_i        (bus_we),
    .bus_irq_raise_o (irq_raise),
    .bus_irq_ack_i   (irq_ack),
    .xcvr            (xif.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every transmit request pops the next expected byte.
  always @(posedge clk) begin
    #1;
    if (xif.send_byte) begin
      n_send++;
      check_eq("tx_queue_nonempty", (exp_tx.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_tx.size() > 0) begin
        check_eq("tx_byte", {24'd0, xif.tx_byte}, {24'd0, exp_tx.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (hold_watch && !xif.hold_stream) hold_drop = 1'b1;
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_data  = d;
    tb_drv   = 1'b1;
    @(negedge clk);
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_we   = 1'b0;
    @(posedge clk);
    #1;
    d = bus_data;
    @(negedge clk);
    bus_addr = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check_eq(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic wait_send(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (xif.send_byte) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_sent();
    @(negedge clk);
    xif.byte_sent = 1'b1;
    @(negedge clk);
    xif.byte_sent = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk);
    xif.rx_ready = 1'b1;
    xif.rx_byte  = b;
    @(negedge clk);
    xif.rx_ready = 1'b0;
  endtask

  task automatic xcvr_byte(input logic [7:0] resp);
    wait_send("send_seen");
    pulse_sent();
    repeat (2) @(negedge clk);
    pulse_rx(resp);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!xif.hold_stream) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst           = 1'b1;
    bus_addr      = 8'h00;
    bus_we        = 1'b0;
    tb_data       = 8'h00;
    tb_drv        = 1'b0;
    irq_ack       = 1'b0;
    xif.byte_sent = 1'b0;
    xif.rx_ready  = 1'b0;
    xif.rx_byte   = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_send", {31'd0, xif.send_byte}, 32'd0);
    check_eq("rst_tx", {24'd0, xif.tx_byte}, 32'd0);
    check_eq("rst_hold", {31'd0, xif.hold_stream}, 32'd0);
    check_eq("rst_raise", {31'd0, irq_raise}, 32'd0);
    rst = 1'b0;
    read_check("rst_status", A_CTRL, 8'h00);

    // 1: single command, no argument
    bus_write(A_CTRL, 8'h00);
    snap = n_send;
    exp_tx.push_back(8'hF4);
    bus_write(A_CMD, 8'hF4);
    xcvr_byte(8'hFA);
    wait_idle("t1_idle");
    check_eq("t1_sends", n_send - snap, 1);
    read_check("t1_status", A_CTRL, 8'h40);
    read_check("t1_resp", A_RESP, 8'hFA);
    check_eq("t1_raise", {31'd0, irq_raise}, 32'd0);

    // 2: command with argument and interrupt
    bus_write(A_CTRL, 8'h03);
    bus_write(A_ARG, 8'h28);
    read_check("t2_arg", A_ARG, 8'h28);
    exp_tx.push_back(8'hF3);
    exp_tx.push_back(8'h28);
    bus_write(A_CMD, 8'hF3);
    xcvr_byte(8'hFA);
    xcvr_byte(8'hFA);
    wait_idle("t2_idle");
    read_check("t2_status", A_CTRL, 8'h40);
    repeat (3) @(negedge clk);
    check_eq("t2_raise_held", {31'd0, irq_raise}, 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check_eq("t2_raise_cleared", {31'd0, irq_raise}, 32'd0);

    // 3: resend exhausted
    bus_write(A_CTRL, 8'h00);
    snap = n_send;
    for (int i = 0; i < 3; i++) exp_tx.push_back(8'hE8);
    bus_write(A_CMD, 8'hE8);
    for (int i = 0; i < 3; i++) xcvr_byte(8'hFE);
    wait_idle("t3_idle");
    check_eq("t3_sends", n_send - snap, 3);
    read_check("t3_status", A_CTRL, 8'h4A);
    read_check("t3_resp", A_RESP, 8'hFE);

    // 4: response timeout
    exp_tx.push_back(8'hF5);
    bus_write(A_CMD, 8'hF5);
    wait_send("t4_send_seen");
    pulse_sent();
    repeat (TMO - 1) @(negedge clk);
    check_eq("t4_no_early_timeout", {31'd0, xif.hold_stream}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t4_hold_released", {31'd0, xif.hold_stream}, 32'd0);
    read_check("t4_status", A_CTRL, 8'h50);

    // 5: overrun write and stray RX while busy
    snap = n_send;
    exp_tx.push_back(8'hF5);
    bus_write(A_CMD, 8'hF5);
    wait_send("t5_send_seen");
    hold_watch = 1'b1;
    bus_write(A_CMD, 8'hFF);
    pulse_rx(8'h55);
    read_check("t5_resp_not_latched", A_RESP, 8'hFE);
    pulse_sent();
    repeat (2) @(negedge clk);
    pulse_rx(8'hFA);
    hold_watch = 1'b0;
    wait_idle("t5_idle");
    check_eq("t5_hold_continuous", {31'd0, hold_drop}, 32'd0);
    check_eq("t5_sends", n_send - snap, 1);
    read_check("t5_status", A_CTRL, 8'h60);
    read_check("t5_resp", A_RESP, 8'hFA);

    // 6: reset while waiting for the response
    exp_tx.push_back(8'hF4);
    bus_write(A_CMD, 8'hF4);
    wait_send("t6_send_seen");
    pulse_sent();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_send", {31'd0, xif.send_byte}, 32'd0);
    check_eq("t6_rst_tx", {24'd0, xif.tx_byte}, 32'd0);
    check_eq("t6_rst_hold", {31'd0, xif.hold_stream}, 32'd0);
    check_eq("t6_rst_raise", {31'd0, irq_raise}, 32'd0);
    rst = 1'b0;
    snap = n_send;
    repeat (5) @(negedge clk);
    check_eq("t6_no_send_after_rst", n_send - snap, 0);
    read_check("t6_status_rst", A_CTRL, 8'h00);
    read_check("t6_resp_rst", A_RESP, 8'h00);
    exp_tx.push_back(8'hF4);
    bus_write(A_CMD, 8'hF4);
    xcvr_byte(8'hFA);
    wait_idle("t6_idle");
    read_check("t6_status", A_CTRL, 8'h40);
    check_eq("queue_drained", exp_tx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
